// File: rtl/line_seq_pkg.sv
// Shared definitions for the Wild Cube obstacle-line sequencer: state encoding,
// lives preset and the frame-counter width helper.
package line_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STAGGER = 3'd2,
    ST_RUN     = 3'd3,
    ST_HIT     = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  localparam logic [1:0] LIVES_INIT  = 2'd3;
  // Line blocks clock their gap counters on frame, so load is held for two ticks.
  localparam int         LOAD_FRAMES = 2;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/line_sequencer_frame_tick_counter.sv
// Counts frame ticks up to a terminal value; done pulses on the tick that
// reaches it and the count restarts from zero.
module frame_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // A clear wins over a coincident tick: that tick is not counted.
  always_comb begin
    done    = tick && !clr && (count_q + W'(1) == term);
    count_d = count_q;
    if (clr || done) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Game-level controller: loads, staggers, freezes and flashes the obstacle
// lines on frame ticks and tracks lives from the collision flag.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int NUM_LINES      = 4,
  parameter int STAGGER_FRAMES = 30,
  parameter int HIT_FRAMES     = 120,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 btn_start,
  input  logic                 collision,
  output logic                 load_counter,
  output logic [NUM_LINES-1:0] start_machine,
  output logic                 move_en,
  output logic                 flash,
  output logic [1:0]           lives,
  output logic [2:0]           state
);

  localparam int CW    = cnt_width(HIT_FRAMES, STAGGER_FRAMES);
  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  state_e               state_q, state_d;
  state_e               ret_q, ret_d;
  logic                 load_q, load_d;
  logic [NUM_LINES-1:0] sm_q, sm_d;
  logic                 move_q, move_d;
  logic                 flash_q, flash_d;
  logic [1:0]           lives_q, lives_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_next;
  logic                 btn_prev_q;

  logic                 start_evt;
  logic                 hit_evt;
  logic                 tc_clr, tc_done;
  logic [CW-1:0]        tc_term;
  logic                 fc_done;

  assign start_evt = btn_start & ~btn_prev_q;
  assign hit_evt   = frame & collision & ((state_q == ST_STAGGER) || (state_q == ST_RUN));
  assign tc_clr    = hit_evt | (start_evt & ((state_q == ST_IDLE) || (state_q == ST_OVER)));

  always_comb begin
    case (state_q)
      ST_LOAD:    tc_term = CW'(LOAD_FRAMES);
      ST_STAGGER: tc_term = CW'(STAGGER_FRAMES);
      default:    tc_term = CW'(HIT_FRAMES);
    endcase
  end

  frame_tick_counter #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .tick  (frame),
    .clr   (tc_clr),
    .term  (tc_term),
    .done  (tc_done)
  );

  // Flash phase restarts on every hit so toggles land at 8, 16, 24... ticks.
  frame_tick_counter #(.W(CW)) u_flash (
    .clk   (clk),
    .rst_n (reset),
    .tick  (frame),
    .clr   (hit_evt),
    .term  (CW'(FLASH_FRAMES)),
    .done  (fc_done)
  );

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    load_d   = load_q;
    sm_d     = sm_q;
    move_d   = move_q;
    flash_d  = flash_q;
    lives_d  = lives_q;
    idx_d    = idx_q;
    idx_next = idx_q + IDX_W'(1);
    case (state_q)
      ST_IDLE: begin
        load_d  = 1'b1;
        move_d  = 1'b0;
        flash_d = 1'b1;
        if (start_evt) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tc_done) begin
          load_d   = 1'b0;
          move_d   = 1'b1;
          idx_d    = '0;
          sm_d[0]  = 1'b1;
          state_d  = (NUM_LINES == 1) ? ST_RUN : ST_STAGGER;
        end
      end
      ST_STAGGER, ST_RUN: begin
        if (hit_evt) begin
          state_d = ST_HIT;
          ret_d   = state_q;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          move_d  = 1'b0;
          flash_d = 1'b0;
        end else if ((state_q == ST_STAGGER) && tc_done) begin
          idx_d          = idx_next;
          sm_d[idx_next] = 1'b1;
          if (idx_next == IDX_W'(NUM_LINES - 1)) state_d = ST_RUN;
        end
      end
      ST_HIT: begin
        if (fc_done) flash_d = ~flash_q;
        if (tc_done) begin
          if (lives_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ret_q;
            move_d  = 1'b1;
            flash_d = 1'b1;
          end
        end
      end
      ST_OVER: begin
        move_d = 1'b0;
        if (fc_done) flash_d = ~flash_q;
        if (start_evt) begin
          state_d = ST_IDLE;
          lives_d = LIVES_INIT;
          sm_d    = '0;
          load_d  = 1'b1;
          flash_d = 1'b1;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      load_q     <= 1'b1;
      sm_q       <= '0;
      move_q     <= 1'b0;
      flash_q    <= 1'b1;
      lives_q    <= LIVES_INIT;
      idx_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      load_q     <= load_d;
      sm_q       <= sm_d;
      move_q     <= move_d;
      flash_q    <= flash_d;
      lives_q    <= lives_d;
      idx_q      <= idx_d;
      btn_prev_q <= btn_start;
    end
  end

  assign load_counter  = load_q;
  assign start_machine = sm_q;
  assign move_en       = move_q;
  assign flash         = flash_q;
  assign lives         = lives_q;
  assign state         = state_q;

endmodule
